// File: rtl/multi_event_waiter.sv
// Repeated event-wait loop: waits NUM_WAITS times for any-of or all-of a masked set of
// single-cycle event pulses, reporting each satisfied wait, then parks in DONE.
module multi_event_waiter #(
    parameter int unsigned NUM_EVENTS = 3,
    parameter int unsigned NUM_WAITS  = 3,
    parameter int unsigned IDX_W      = $clog2(NUM_WAITS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  mode,
    input  logic [NUM_EVENTS-1:0] evt_mask,
    input  logic [NUM_EVENTS-1:0] evt_i,
    output logic                  waiting,
    output logic                  got_event,
    output logic [NUM_EVENTS-1:0] got_mask,
    output logic [IDX_W-1:0]      wait_idx,
    output logic                  done,
    output logic                  err
);

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

    state_e                state_q;
    logic                  mode_q;
    logic [NUM_EVENTS-1:0] mask_q;
    logic [NUM_EVENTS-1:0] pending_q;
    logic [IDX_W-1:0]      counter_q;

    logic [NUM_EVENTS-1:0] hit;
    logic [NUM_EVENTS-1:0] acc;
    logic                  fire;
    logic                  last;

    always_comb begin
        hit  = evt_i & mask_q;
        acc  = pending_q | hit;
        fire = 1'b0;
        if (state_q == StWait) begin
            fire = mode_q ? (acc == mask_q) : (hit != '0);
        end
        last = (counter_q == IDX_W'(NUM_WAITS - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            mode_q    <= 1'b0;
            mask_q    <= '0;
            pending_q <= '0;
            counter_q <= '0;
            waiting   <= 1'b0;
            got_event <= 1'b0;
            got_mask  <= '0;
            wait_idx  <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            got_event <= 1'b0;
            case (state_q)
                StIdle, StDone: begin
                    // Events arriving here have no waiter and are dropped.
                    if (start) begin
                        mode_q    <= mode;
                        mask_q    <= evt_mask;
                        pending_q <= '0;
                        counter_q <= '0;
                        if (evt_mask == '0) begin
                            state_q <= StDone;
                            waiting <= 1'b0;
                            done    <= 1'b1;
                            err     <= 1'b1;
                        end else begin
                            state_q <= StWait;
                            waiting <= 1'b1;
                            done    <= 1'b0;
                            err     <= 1'b0;
                        end
                    end
                end
                StWait: begin
                    if (fire) begin
                        got_event <= 1'b1;
                        got_mask  <= mode_q ? mask_q : hit;
                        wait_idx  <= counter_q;
                        counter_q <= counter_q + IDX_W'(1);
                        pending_q <= '0;
                        if (last) begin
                            state_q <= StDone;
                            waiting <= 1'b0;
                            done    <= 1'b1;
                        end
                    end else begin
                        pending_q <= acc;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    waiting <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multi_event_waiter.sv
// Directed bench for multi_event_waiter: per-cycle compare against a wait-loop model plus
// hand-computed literal expectations for the key scenarios.
module tb_multi_event_waiter;

    localparam int NE = 3;
    localparam int NW = 3;
    localparam int IW = $clog2(NW + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          mode = 1'b0;
    logic [NE-1:0] evt_mask = '0;
    logic [NE-1:0] evt_i = '0;
    logic          waiting;
    logic          got_event;
    logic [NE-1:0] got_mask;
    logic [IW-1:0] wait_idx;
    logic          done;
    logic          err;

    int n_checks = 0;
    int n_fails  = 0;

    multi_event_waiter #(
        .NUM_EVENTS(NE),
        .NUM_WAITS (NW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .mode     (mode),
        .evt_mask (evt_mask),
        .evt_i    (evt_i),
        .waiting  (waiting),
        .got_event(got_event),
        .got_mask (got_mask),
        .wait_idx (wait_idx),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a run is "waits_left" more satisfactions of the masked condition.
    bit            m_armed, m_done, m_err, m_got, m_mode;
    int            m_left, m_widx;
    logic [NE-1:0] m_mask, m_seen, m_gmask, m_hits;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_armed = 0; m_done = 0; m_err = 0; m_got = 0; m_mode = 0;
            m_left = 0; m_widx = 0; m_mask = '0; m_seen = '0; m_gmask = '0;
        end else begin
            m_got = 0;
            if (m_armed) begin
                m_hits = evt_i & m_mask;
                if (m_mode ? ((m_seen | m_hits) == m_mask) : (m_hits != '0)) begin
                    m_got   = 1;
                    m_gmask = m_mode ? m_mask : m_hits;
                    m_widx  = NW - m_left;
                    m_left  = m_left - 1;
                    m_seen  = '0;
                    if (m_left == 0) begin
                        m_armed = 0;
                        m_done  = 1;
                    end
                end else begin
                    m_seen = m_seen | m_hits;
                end
            end else if (start) begin
                m_mode  = mode;
                m_mask  = evt_mask;
                m_seen  = '0;
                m_left  = NW;
                m_err   = (evt_mask == '0);
                m_done  = (evt_mask == '0);
                m_armed = (evt_mask != '0);
            end
        end
    end

    always @(negedge clk) begin
        chk("waiting", int'(waiting), int'(m_armed));
        chk("got_event", int'(got_event), int'(m_got));
        chk("got_mask", int'(got_mask), int'(m_gmask));
        chk("wait_idx", int'(wait_idx), m_widx);
        chk("done", int'(done), int'(m_done));
        chk("err", int'(err), int'(m_err));
    end

    // Drive one cycle of inputs, then land 1 time unit after the closing edge.
    task automatic cyc(input bit s, input bit md, input logic [NE-1:0] msk,
                       input logic [NE-1:0] ev);
        start    = s;
        mode     = md;
        evt_mask = msk;
        evt_i    = ev;
        @(posedge clk);
        #1;
        start = 0;
        evt_i = '0;
    endtask

    initial begin
        @(posedge clk);
        #1;
        rst = 0;
        chk("reset_waiting", int'(waiting), 0);
        chk("reset_done", int'(done), 0);

        // Pulse in IDLE is lost.
        cyc(0, 0, 3'b111, 3'b001);
        chk("idle_lost_got", int'(got_event), 0);
        chk("idle_lost_wait", int'(waiting), 0);

        // ANY, one event at a time.
        cyc(1, 0, 3'b111, 3'b000);               // c0
        chk("any_waiting", int'(waiting), 1);
        cyc(0, 0, 3'b000, 3'b000);               // c1
        cyc(0, 0, 3'b000, 3'b001);               // c2
        chk("any_got0", int'(got_event), 1);
        chk("any_mask0", int'(got_mask), 1);
        chk("any_idx0", int'(wait_idx), 0);
        cyc(0, 0, 3'b000, 3'b000);               // c3
        chk("any_pulse", int'(got_event), 0);
        chk("any_hold", int'(got_mask), 1);
        cyc(0, 0, 3'b000, 3'b010);               // c4
        chk("any_mask1", int'(got_mask), 2);
        chk("any_idx1", int'(wait_idx), 1);
        cyc(0, 0, 3'b000, 3'b000);               // c5
        cyc(0, 0, 3'b000, 3'b100);               // c6
        chk("any_mask2", int'(got_mask), 4);
        chk("any_idx2", int'(wait_idx), 2);
        chk("any_done", int'(done), 1);
        chk("any_wait_off", int'(waiting), 0);
        cyc(0, 0, 3'b000, 3'b001);               // pulse in DONE
        chk("done_lost_got", int'(got_event), 0);
        chk("done_stays", int'(done), 1);

        // Back-to-back start from DONE with an event in the start cycle (lost).
        cyc(1, 0, 3'b111, 3'b101);
        chk("start_evt_lost", int'(got_event), 0);
        chk("restart_done", int'(done), 0);
        cyc(0, 0, 3'b000, 3'b000);
        cyc(0, 0, 3'b000, 3'b101);
        chk("simul_got", int'(got_event), 1);
        chk("simul_mask", int'(got_mask), 5);
        chk("simul_idx", int'(wait_idx), 0);
        cyc(0, 0, 3'b000, 3'b010);
        chk("simul_next_idx", int'(wait_idx), 1);
        cyc(0, 0, 3'b000, 3'b001);
        chk("simul_done", int'(done), 1);

        // ALL, mask 011: repeats absorbed, C ignored.
        cyc(1, 1, 3'b011, 3'b000);
        cyc(0, 0, 3'b000, 3'b000);
        cyc(0, 0, 3'b000, 3'b001);
        chk("all_no_fire_a", int'(got_event), 0);
        cyc(0, 0, 3'b000, 3'b001);
        cyc(0, 0, 3'b000, 3'b100);
        chk("all_no_fire_c", int'(got_event), 0);
        cyc(0, 0, 3'b000, 3'b010);
        chk("all_got", int'(got_event), 1);
        chk("all_mask", int'(got_mask), 3);
        chk("all_idx", int'(wait_idx), 0);
        // Start in WAIT is ignored; C stays outside the latched mask.
        cyc(1, 0, 3'b100, 3'b100);
        chk("wait_start_ign", int'(got_event), 0);
        cyc(0, 0, 3'b000, 3'b001);
        chk("wait_still", int'(waiting), 1);
        chk("all_pend_only", int'(got_event), 0);

        // Reset mid-WAIT coincident with the completing event.
        evt_i = 3'b010;
        #2;
        rst = 1;
        #1;
        chk("rst_waiting", int'(waiting), 0);
        chk("rst_got_mask", int'(got_mask), 0);
        chk("rst_wait_idx", int'(wait_idx), 0);
        @(posedge clk);
        #1;
        rst = 0;
        evt_i = '0;
        chk("rst_no_got", int'(got_event), 0);
        cyc(0, 0, 3'b000, 3'b011);
        chk("rst_after_got", int'(got_event), 0);

        // Empty mask ends the run with err, then a normal run clears it.
        cyc(1, 0, 3'b000, 3'b000);
        chk("empty_done", int'(done), 1);
        chk("empty_err", int'(err), 1);
        chk("empty_waiting", int'(waiting), 0);
        cyc(0, 0, 3'b000, 3'b111);
        chk("empty_no_got", int'(got_event), 0);
        cyc(1, 0, 3'b001, 3'b000);
        chk("err_cleared", int'(err), 0);
        for (int i = 0; i < NW; i++) begin
            cyc(0, 0, 3'b000, 3'b001);
            chk("post_rst_idx", int'(wait_idx), i);
            chk("post_rst_got", int'(got_event), 1);
        end
        chk("post_rst_done", int'(done), 1);
        cyc(0, 0, 3'b000, 3'b000);
        cyc(0, 0, 3'b000, 3'b000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
